// File: rtl/vacancy_debouncer.sv
// Two-flop synchroniser plus per-spot debounce for the parking-spot switches.
// Emits clean spot state, arrival/departure pulses and a saturating arrival total.
module vacancy_debouncer #(
  parameter int unsigned N_SPOTS         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SPOTS-1:0] CH_raw,
  input  logic               clr_total,
  output logic [N_SPOTS-1:0] CH,
  output logic [N_SPOTS-1:0] arrive,
  output logic [N_SPOTS-1:0] depart,
  output logic               changed,
  output logic [7:0]         arrivals_total
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned      PopW    = $clog2(N_SPOTS + 1);
  localparam int unsigned      SumW    = PopW + 8;

  logic [N_SPOTS-1:0] sync1, sync2;
  logic [CNT_W-1:0]   cnt_q [N_SPOTS];
  logic [CNT_W-1:0]   cnt_d [N_SPOTS];
  logic [N_SPOTS-1:0] ch_d, arrive_d, depart_d;
  logic               changed_d;
  logic [PopW-1:0]    pop;
  logic [SumW-1:0]    sum;
  logic [7:0]         total_d;

  // Debounce: a channel follows sync2 only after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    ch_d     = CH;
    arrive_d = '0;
    depart_d = '0;
    for (int i = 0; i < int'(N_SPOTS); i++) begin
      cnt_d[i] = '0;
      if (sync2[i] != CH[i]) begin
        if (cnt_q[i] == CntLast) begin
          ch_d[i]     = sync2[i];
          arrive_d[i] = sync2[i];
          depart_d[i] = ~sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = (|arrive_d) | (|depart_d);
  end

  // The total counts the already-registered arrive pulses, so it lags them by one cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(N_SPOTS); i++) begin
      pop = pop + PopW'(arrive[i]);
    end
    sum = SumW'(arrivals_total) + SumW'(pop);
    if (clr_total) begin
      total_d = 8'd0;
    end else if (sum > SumW'(255)) begin
      total_d = 8'hFF;
    end else begin
      total_d = sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1          <= '0;
      sync2          <= '0;
      CH             <= '0;
      arrive         <= '0;
      depart         <= '0;
      changed        <= 1'b0;
      arrivals_total <= 8'd0;
    end else begin
      sync1          <= CH_raw;
      sync2          <= sync1;
      CH             <= ch_d;
      arrive         <= arrive_d;
      depart         <= depart_d;
      changed        <= changed_d;
      arrivals_total <= total_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_SPOTS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_SPOTS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_vacancy_debouncer.sv
// Bench for vacancy_debouncer: directed plus random stimulus against a sample-window model.
// The model fires a channel when the last D synchronised samples all disagree with CH.
module tb_vacancy_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_total;
  logic [7:0] CH_raw;
  logic [7:0] CH;
  logic [7:0] arrive;
  logic [7:0] depart;
  logic       changed;
  logic [7:0] arrivals_total;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] rawq[$];
  logic [7:0] m_ch  = '0;
  logic [7:0] m_arr = '0;
  logic [7:0] m_dep = '0;
  logic [7:0] m_tot = '0;

  vacancy_debouncer #(
    .N_SPOTS        (8),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .CH_raw        (CH_raw),
    .clr_total     (clr_total),
    .CH            (CH),
    .arrive        (arrive),
    .depart        (depart),
    .changed       (changed),
    .arrivals_total(arrivals_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Synchronised sample seen at edge idx is the raw value captured two edges earlier.
  function automatic logic s_bit(input int idx, input int b);
    logic [7:0] v;
    if (idx < 0) return 1'b0;
    v = rawq[idx];
    return v[b];
  endfunction

  task automatic model_edge(input logic [7:0] r, input logic c);
    int         t;
    int         tmp;
    logic [7:0] fire;
    rawq.push_back(r);
    t    = rawq.size() - 1;
    fire = '0;
    for (int i = 0; i < 8; i++) begin
      logic f;
      f = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (s_bit(t - j - 2, i) == m_ch[i]) f = 1'b0;
      end
      fire[i] = f;
    end
    tmp   = int'(m_tot) + $countones(m_arr);
    m_tot = c ? 8'd0 : ((tmp > 255) ? 8'hFF : 8'(tmp));
    m_arr = fire & ~m_ch;
    m_dep = fire & m_ch;
    m_ch  = m_ch ^ fire;
  endtask

  task automatic check_all();
    chk("CH", CH, m_ch);
    chk("arrive", arrive, m_arr);
    chk("depart", depart, m_dep);
    chk("changed", {7'b0, changed}, {7'b0, |(m_arr | m_dep)});
    chk("arrivals_total", arrivals_total, m_tot);
  endtask

  task automatic step(input logic [7:0] r, input logic c);
    @(negedge clk);
    CH_raw    = r;
    clr_total = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [7:0] r, input int n);
    for (int k = 0; k < n; k++) step(r, 1'b0);
  endtask

  task automatic model_reset();
    rawq.delete();
    m_ch  = '0;
    m_arr = '0;
    m_dep = '0;
    m_tot = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_CH"}, CH, 8'h00);
    chk({tag, "_arrive"}, arrive, 8'h00);
    chk({tag, "_depart"}, depart, 8'h00);
    chk({tag, "_changed"}, {7'b0, changed}, 8'h00);
    chk({tag, "_total"}, arrivals_total, 8'h00);
  endtask

  // Returns the 0-based step index at which CH changes, or -1 if it never does.
  task automatic wait_ch_change(input logic [7:0] r, output int n);
    logic [7:0] prev;
    prev = CH;
    n    = -1;
    for (int k = 0; k < 20; k++) begin
      step(r, 1'b0);
      if (CH !== prev) begin
        n = k;
        return;
      end
    end
  endtask

  initial begin
    int         n;
    logic [7:0] cur;
    int         len;

    rst       = 1'b1;
    CH_raw    = 8'h00;
    clr_total = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Clean single-bit arrival.
    wait_ch_change(8'h01, n);
    chk("clean_latency", 8'(n), 8'd5);
    chk("clean_arrive", arrive, 8'h01);
    chk("clean_changed", {7'b0, changed}, 8'h01);
    step(8'h01, 1'b0);
    chk("clean_total", arrivals_total, 8'd1);
    chk("clean_pulse_gone", arrive, 8'h00);
    hold(8'h00, 8);

    // Short bounce never reaches CH.
    hold(8'h08, 3);
    hold(8'h00, 10);
    chk("glitch_CH", CH, 8'h00);

    // One-cycle dip restarts the count.
    hold(8'h08, 3);
    step(8'h00, 1'b0);
    wait_ch_change(8'h08, n);
    chk("dip_latency", 8'(n), 8'd5);
    hold(8'h00, 8);

    // Simultaneous arrivals and departures.
    hold(8'h0F, 8);
    wait_ch_change(8'hF0, n);
    chk("simul_CH", CH, 8'hF0);
    chk("simul_arrive", arrive, 8'hF0);
    chk("simul_depart", depart, 8'h0F);
    chk("simul_changed", {7'b0, changed}, 8'h01);
    hold(8'hF0, 2);

    // Random bouncing inputs.
    cur = 8'hF0;
    for (int seg = 0; seg < 80; seg++) begin
      cur = cur ^ (8'($urandom) & 8'($urandom));
      len = $urandom_range(1, 8);
      hold(cur, len);
    end

    // Saturation at 255.
    hold(8'h00, 8);
    for (int k = 0; k < 70; k++) begin
      hold(8'h00, 8);
      hold(8'hFF, 8);
    end
    chk("sat_total", arrivals_total, 8'hFF);

    // Clear wins over a same-cycle increment.
    hold(8'h00, 8);
    for (int k = 0; k < 20 && m_arr != 8'hFF; k++) step(8'hFF, 1'b0);
    chk("clr_pulse", arrive, 8'hFF);
    step(8'hFF, 1'b1);
    chk("clr_total", arrivals_total, 8'h00);

    // Asynchronous reset during a debounce in progress.
    hold(8'hAA, 8);
    hold(8'hAB, 2);
    #1 rst = 1'b1;
    #1;
    check_reset_state("arst");
    #1 rst = 1'b0;
    model_reset();
    wait_ch_change(8'hAA, n);
    chk("arst_latency", 8'(n), 8'd5);
    chk("arst_arrive", arrive, 8'hAA);
    hold(8'hAA, 3);
    chk("arst_total", arrivals_total, 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
